// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic SRC_PIPE = 1'b0;
  localparam logic SRC_MDU  = 1'b1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Write-back / MDU / register-file signal bundle around the write-port arbiter.
interface wb_port_arbiter_if;
  import wb_arb_pkg::*;

  logic                  wb_reg_wr_en;
  logic [REG_ADDR_W-1:0] wb_reg_wr_addr;
  logic [DATA_W-1:0]     wb_reg_wr_data;
  logic                  mdu_valid;
  logic [REG_ADDR_W-1:0] mdu_addr;
  logic [DATA_W-1:0]     mdu_data;
  logic                  mdu_ready;
  logic                  rf_wr_en;
  logic [REG_ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0]     rf_wr_data;
  logic                  rf_wr_src;
  logic                  stall_req;
  logic [31:0]           pend_mask;

  modport slave (
    input  wb_reg_wr_en, wb_reg_wr_addr, wb_reg_wr_data,
    input  mdu_valid, mdu_addr, mdu_data,
    output mdu_ready, rf_wr_en, rf_wr_addr, rf_wr_data, rf_wr_src,
    output stall_req, pend_mask
  );

  modport master (
    output wb_reg_wr_en, wb_reg_wr_addr, wb_reg_wr_data,
    output mdu_valid, mdu_addr, mdu_data,
    input  mdu_ready, rf_wr_en, rf_wr_addr, rf_wr_data, rf_wr_src,
    input  stall_req, pend_mask
  );

endinterface

// File: rtl/wb_pend_fifo.sv
// Buffer for MDU results waiting on an idle write-port slot; exposes
// per-entry valid/address so the top can build the pending-write mask.
module wb_pend_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_push,
  input  logic                                i_pop,
  input  wb_entry_t                           i_din,
  output logic                                o_full,
  output logic                                o_empty,
  output wb_entry_t                           o_head,
  output logic [DEPTH-1:0]                    o_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    o_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [DEPTH-1:0]   r_valid;

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pop clears before push sets so a same-index push keeps its valid bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (i_pop) begin
        r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
        r_valid[r_rd_ptr] <= 1'b0;
      end
      if (i_push) begin
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
        r_valid[r_wr_ptr] <= 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    o_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_addr[i] = r_mem[i].addr;
    end
  end

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == CNT_W'(0));
  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = r_valid;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, MDU
// results bypass or are buffered and drained into idle slots.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  wb_port_arbiter_if.slave   bus
);

  localparam int ST_W = $clog2(STARVE_LIMIT + 1);

  logic                             w_busy;
  logic                             w_hs;
  logic                             w_mdu_nz;
  logic                             w_pop;
  logic                             w_push;
  logic                             w_bypass;
  logic                             w_full;
  logic                             w_empty;
  wb_entry_t                        w_head;
  wb_entry_t                        w_din;
  logic [DEPTH-1:0]                 w_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] w_addr;
  logic [31:0]                      w_pend;
  logic [ST_W-1:0]                  r_starve_cnt;

  assign w_busy   = bus.wb_reg_wr_en && (bus.wb_reg_wr_addr != REG_ADDR_W'(0));
  assign w_hs     = bus.mdu_valid && !w_full && !rst;
  assign w_mdu_nz = (bus.mdu_addr != REG_ADDR_W'(0));
  assign w_pop    = !w_busy && !w_empty && !rst;
  // Bypass only when nothing older is queued, so ordering is never violated.
  assign w_bypass = !w_busy && w_empty && w_hs && w_mdu_nz;
  assign w_push   = w_hs && w_mdu_nz && !w_bypass;
  assign w_din    = '{addr: bus.mdu_addr, data: bus.mdu_data};

  wb_pend_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head),
    .o_valid (w_valid),
    .o_addr  (w_addr)
  );

  always_ff @(posedge clk) begin
    if (rst || w_empty || w_pop) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != ST_W'(STARVE_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + ST_W'(1);
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i]) begin
        w_pend[w_addr[i]] = 1'b1;
      end
    end
  end

  always_comb begin
    bus.rf_wr_en   = 1'b0;
    bus.rf_wr_addr = '0;
    bus.rf_wr_data = '0;
    bus.rf_wr_src  = SRC_PIPE;
    if (rst) begin
      bus.rf_wr_en = 1'b0;
    end else if (w_busy) begin
      bus.rf_wr_en   = 1'b1;
      bus.rf_wr_addr = bus.wb_reg_wr_addr;
      bus.rf_wr_data = bus.wb_reg_wr_data;
    end else if (w_pop) begin
      bus.rf_wr_en   = 1'b1;
      bus.rf_wr_addr = w_head.addr;
      bus.rf_wr_data = w_head.data;
      bus.rf_wr_src  = SRC_MDU;
    end else if (w_bypass) begin
      bus.rf_wr_en   = 1'b1;
      bus.rf_wr_addr = bus.mdu_addr;
      bus.rf_wr_data = bus.mdu_data;
      bus.rf_wr_src  = SRC_MDU;
    end else begin
      bus.rf_wr_en = 1'b0;
    end
  end

  assign bus.mdu_ready = !rst && !w_full;
  assign bus.stall_req = !rst && (r_starve_cnt == ST_W'(STARVE_LIMIT));
  assign bus.pend_mask = rst ? 32'h0 : w_pend;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (DEPTH=4, STARVE_LIMIT=8).
module tb_wb_port_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  wb_port_arbiter_if bus_if ();

  wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge; return at the falling edge.
  task automatic cyc(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic mv, input logic [4:0] ma, input logic [31:0] md);
    @(posedge clk);
    #1;
    rst                   = r;
    bus_if.wb_reg_wr_en   = we;
    bus_if.wb_reg_wr_addr = wa;
    bus_if.wb_reg_wr_data = wd;
    bus_if.mdu_valid      = mv;
    bus_if.mdu_addr       = ma;
    bus_if.mdu_data       = md;
    @(negedge clk);
  endtask

  task automatic check_port(input string tag, input logic en, input logic [4:0] a,
                            input logic [31:0] d, input logic src);
    check_eq({tag, ".en"}, 32'(bus_if.rf_wr_en), 32'(en));
    if (en) begin
      check_eq({tag, ".addr"}, 32'(bus_if.rf_wr_addr), 32'(a));
      check_eq({tag, ".data"}, bus_if.rf_wr_data, d);
      check_eq({tag, ".src"}, 32'(bus_if.rf_wr_src), 32'(src));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst                   = 1'b1;
    bus_if.wb_reg_wr_en   = 1'b1;
    bus_if.wb_reg_wr_addr = 5'd3;
    bus_if.wb_reg_wr_data = 32'hDEAD_BEEF;
    bus_if.mdu_valid      = 1'b1;
    bus_if.mdu_addr       = 5'd9;
    bus_if.mdu_data       = 32'h0000_0099;
    @(negedge clk);
    check_eq("rst.en", 32'(bus_if.rf_wr_en), 32'd0);
    check_eq("rst.ready", 32'(bus_if.mdu_ready), 32'd0);
    check_eq("rst.stall", 32'(bus_if.stall_req), 32'd0);
    check_eq("rst.pend", bus_if.pend_mask, 32'h0);

    // Idle after reset, then bypass of r5.
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check_eq("idle.ready", 32'(bus_if.mdu_ready), 32'd1);
    check_eq("idle.stall", 32'(bus_if.stall_req), 32'd0);
    check_eq("idle.pend", bus_if.pend_mask, 32'h0);
    check_eq("idle.en", 32'(bus_if.rf_wr_en), 32'd0);
    check_eq("idle.src", 32'(bus_if.rf_wr_src), 32'd0);
    check_eq("idle.addr", 32'(bus_if.rf_wr_addr), 32'd0);
    check_eq("idle.data", bus_if.rf_wr_data, 32'h0);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h0000_1234);
    check_port("byp", 1'b1, 5'd5, 32'h0000_1234, 1'b1);
    check_eq("byp.pend", bus_if.pend_mask, 32'h0);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check_port("byp.after", 1'b0, 5'd0, 32'h0, 1'b0);
    check_eq("byp.after.pend", bus_if.pend_mask, 32'h0);

    // Pipeline busy on r3 while r7, r8 are buffered and drained afterwards.
    cyc(1'b0, 1'b1, 5'd3, 32'h0000_0A03, 1'b1, 5'd7, 32'h0000_0077);
    check_port("buf.c1", 1'b1, 5'd3, 32'h0000_0A03, 1'b0);
    check_eq("buf.c1.pend", bus_if.pend_mask, 32'h0);
    cyc(1'b0, 1'b1, 5'd3, 32'h0000_0A03, 1'b1, 5'd8, 32'h0000_0088);
    check_port("buf.c2", 1'b1, 5'd3, 32'h0000_0A03, 1'b0);
    check_eq("buf.c2.pend", bus_if.pend_mask, 32'h0000_0080);
    cyc(1'b0, 1'b1, 5'd3, 32'h0000_0A03, 1'b0, 5'd0, 32'h0);
    check_port("buf.c3", 1'b1, 5'd3, 32'h0000_0A03, 1'b0);
    check_eq("buf.c3.pend", bus_if.pend_mask, 32'h0000_0180);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check_port("buf.d1", 1'b1, 5'd7, 32'h0000_0077, 1'b1);
    check_eq("buf.d1.pend", bus_if.pend_mask, 32'h0000_0180);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check_port("buf.d2", 1'b1, 5'd8, 32'h0000_0088, 1'b1);
    check_eq("buf.d2.pend", bus_if.pend_mask, 32'h0000_0100);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check_port("buf.d3", 1'b0, 5'd0, 32'h0, 1'b0);
    check_eq("buf.d3.pend", bus_if.pend_mask, 32'h0);

    // Fill to DEPTH, fifth result is held by mdu_ready=0, then ordered drain.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 5'd1, 32'h0000_0B01, 1'b1, 5'(10 + i), 32'(32'h100 + 10 + i));
      check_eq($sformatf("full.push%0d.ready", i), 32'(bus_if.mdu_ready), 32'd1);
      check_port($sformatf("full.push%0d", i), 1'b1, 5'd1, 32'h0000_0B01, 1'b0);
    end
    cyc(1'b0, 1'b1, 5'd1, 32'h0000_0B01, 1'b1, 5'd14, 32'h0000_010E);
    check_eq("full.ready", 32'(bus_if.mdu_ready), 32'd0);
    check_eq("full.pend", bus_if.pend_mask, 32'h0000_3C00);
    cyc(1'b0, 1'b1, 5'd1, 32'h0000_0B01, 1'b1, 5'd14, 32'h0000_010E);
    check_eq("full.ready2", 32'(bus_if.mdu_ready), 32'd0);
    check_eq("full.nostall", 32'(bus_if.stall_req), 32'd0);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'h0000_010E);
    check_port("full.d10", 1'b1, 5'd10, 32'h0000_010A, 1'b1);
    check_eq("full.d10.ready", 32'(bus_if.mdu_ready), 32'd0);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'h0000_010E);
    check_port("full.d11", 1'b1, 5'd11, 32'h0000_010B, 1'b1);
    check_eq("full.d11.ready", 32'(bus_if.mdu_ready), 32'd1);
    for (int i = 12; i <= 14; i++) begin
      cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      check_port($sformatf("full.d%0d", i), 1'b1, 5'(i), 32'(32'h100 + i), 1'b1);
    end
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check_port("full.empty", 1'b0, 5'd0, 32'h0, 1'b0);
    check_eq("full.empty.pend", bus_if.pend_mask, 32'h0);

    // Starvation: one entry under continuous pipeline writes.
    cyc(1'b0, 1'b1, 5'd2, 32'h0000_00B0, 1'b1, 5'd20, 32'h0000_2020);
    check_eq("stv.push.stall", 32'(bus_if.stall_req), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0, 1'b1, 5'd2, 32'h0000_00B0, 1'b0, 5'd0, 32'h0);
      check_eq($sformatf("stv.k%0d.stall", k), 32'(bus_if.stall_req), 32'd0);
    end
    check_eq("stv.pend", bus_if.pend_mask, 32'h0010_0000);
    cyc(1'b0, 1'b1, 5'd2, 32'h0000_00B0, 1'b0, 5'd0, 32'h0);
    check_eq("stv.rise", 32'(bus_if.stall_req), 32'd1);
    check_port("stv.rise.port", 1'b1, 5'd2, 32'h0000_00B0, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check_port("stv.drain", 1'b1, 5'd20, 32'h0000_2020, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check_eq("stv.fall", 32'(bus_if.stall_req), 32'd0);
    check_eq("stv.fall.pend", bus_if.pend_mask, 32'h0);

    // r0 from both sources: nothing written, nothing buffered.
    cyc(1'b0, 1'b1, 5'd0, 32'h0000_5555, 1'b1, 5'd0, 32'h0000_FFFF);
    check_eq("r0.en", 32'(bus_if.rf_wr_en), 32'd0);
    check_eq("r0.ready", 32'(bus_if.mdu_ready), 32'd1);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check_eq("r0.next.en", 32'(bus_if.rf_wr_en), 32'd0);
    check_eq("r0.next.pend", bus_if.pend_mask, 32'h0);
    check_eq("r0.next.ready", 32'(bus_if.mdu_ready), 32'd1);

    // Reset with three buffered entries discards them.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 5'd4, 32'h0000_0C04, 1'b1, 5'(21 + i), 32'(32'h200 + i));
    end
    cyc(1'b1, 1'b1, 5'd4, 32'h0000_0C04, 1'b0, 5'd0, 32'h0);
    check_eq("mrst.en", 32'(bus_if.rf_wr_en), 32'd0);
    check_eq("mrst.ready", 32'(bus_if.mdu_ready), 32'd0);
    check_eq("mrst.pend", bus_if.pend_mask, 32'h0);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check_eq("mrst.after.en", 32'(bus_if.rf_wr_en), 32'd0);
    check_eq("mrst.after.ready", 32'(bus_if.mdu_ready), 32'd1);
    check_eq("mrst.after.pend", bus_if.pend_mask, 32'h0);
    check_eq("mrst.after.stall", 32'(bus_if.stall_req), 32'd0);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check_eq("mrst.after2.en", 32'(bus_if.rf_wr_en), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
